id_scoreboard: RTL

//  Parametrised register scoreboard and hazard unit for the ID stage.

---
 rtl/id_scoreboard.sv | 99 +++++++++
 1 files changed

// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard: tracks in-flight writers per downstream stage and
// derives forward selects, load-use stall, issue enable and a saturating stall count.
module id_scoreboard #(
  parameter int RF_AW       = 5,
  parameter int NUM_STAGES  = 3,
  parameter int LOAD_LAT    = 2,
  parameter int FLUSH_DEPTH = 0,
  parameter int CNT_W       = 16,
  localparam int FW         = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_rs1_rd,
  input  logic [RF_AW-1:0] id_rs1_addr,
  input  logic             id_rs2_rd,
  input  logic [RF_AW-1:0] id_rs2_addr,
  input  logic             id_reg_wen,
  input  logic [RF_AW-1:0] id_reg_waddr,
  input  logic             id_mem_rd,
  input  logic             pipe_adv,
  input  logic             flush,
  output logic             id_ready,
  output logic             hazard_stall,
  output logic [FW-1:0]    rs1_fwd_sel,
  output logic [FW-1:0]    rs2_fwd_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ent_v  [1:NUM_STAGES];
  logic [RF_AW-1:0] ent_wa [1:NUM_STAGES];
  logic             ent_ld [1:NUM_STAGES];
  logic             live   [1:NUM_STAGES];

  logic [FW-1:0] sel1, sel2;
  logic          late1, late2;
  logic          issue;

  // Valid bits after the flush kill mask; used only for the state update.
  always_comb begin
    for (int k = 1; k <= NUM_STAGES; k++) begin
      live[k] = ent_v[k] & ~(flush & (k <= FLUSH_DEPTH));
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    sel1  = '0;
    sel2  = '0;
    late1 = 1'b0;
    late2 = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (id_rs1_rd && (id_rs1_addr != '0) && ent_v[k] && (ent_wa[k] == id_rs1_addr)) begin
        sel1  = FW'(k);
        late1 = ent_ld[k] && (k < LOAD_LAT);
      end
      if (id_rs2_rd && (id_rs2_addr != '0) && ent_v[k] && (ent_wa[k] == id_rs2_addr)) begin
        sel2  = FW'(k);
        late2 = ent_ld[k] && (k < LOAD_LAT);
      end
    end
  end

  assign rs1_fwd_sel  = sel1;
  assign rs2_fwd_sel  = sel2;
  assign hazard_stall = id_valid & (late1 | late2);
  assign id_ready     = pipe_adv & ~hazard_stall & ~flush;
  assign issue        = id_valid & id_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        ent_v[k]  <= 1'b0;
        ent_wa[k] <= '0;
        ent_ld[k] <= 1'b0;
      end
      stall_cnt <= '0;
    end else begin
      if (pipe_adv) begin
        ent_v[1]  <= issue & id_reg_wen & (id_reg_waddr != '0);
        ent_wa[1] <= id_reg_waddr;
        ent_ld[1] <= id_mem_rd;
        for (int k = 2; k <= NUM_STAGES; k++) begin
          ent_v[k]  <= live[k-1];
          ent_wa[k] <= ent_wa[k-1];
          ent_ld[k] <= ent_ld[k-1];
        end
      end else begin
        for (int k = 1; k <= NUM_STAGES; k++) begin
          ent_v[k] <= live[k];
        end
      end
      if (hazard_stall && pipe_adv && !flush && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
